// File: rtl/apb_i2c_completer.sv
// APB3 completer exposing CTRL/STATUS/ADDR plus TX/RX byte FIFOs to an I2C engine.
// Optional macro APB_SLVERR_EN: when defined, error cases are reported on pslverr.
module apb_i2c_completer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       i2c_en,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       i2c_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        state_q, state_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          commit;

  logic          en_q, start_q, ovf_q;
  logic [6:0]    addr_q;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          sel_ok, wr_commit, rd_commit;
  logic [2:0]    reg_sel;
  logic [7:0]    rdata;
  logic          err;
  logic          tx_push, tx_pop, rx_push, rx_pop, ovf_set, ovf_clr;

  // Transfer FSM: the access completes only once the wait counter drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (psel && !penable) state_d = S_SETUP;
      S_SETUP: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCESS;
          wcnt_d  = 3'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          commit  = !rst;
          state_d = (psel && !penable) ? S_SETUP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign sel_ok    = (paddr[7:3] == 5'd0);
  assign reg_sel   = paddr[2:0];
  assign wr_commit = commit && pwrite && sel_ok;
  assign rd_commit = commit && !pwrite && sel_ok;

  always_comb begin
    rdata = 8'h00;
    err   = 1'b0;
    if (!sel_ok) begin
      err = 1'b1;
    end else begin
      case (reg_sel)
        3'd0: rdata = {7'd0, en_q};
        3'd1: rdata = {2'b00, ovf_q, i2c_busy, rx_empty, rx_full, tx_empty, tx_full};
        3'd2: err = pwrite && tx_full;
        3'd3: begin
          if (pwrite || rx_empty) err = 1'b1;
          else                    rdata = rx_mem[rx_rptr_q];
        end
        3'd4: rdata = {1'b0, addr_q};
        default: err = 1'b1;
      endcase
    end
  end

  assign pready = commit;
  assign prdata = (commit && !pwrite) ? rdata : 8'h00;
`ifdef APB_SLVERR_EN
  assign pslverr = commit && err;
`else
  assign pslverr = 1'b0;
`endif

  assign tx_push = wr_commit && (reg_sel == 3'd2) && !tx_full;
  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_pop  = rd_commit && (reg_sel == 3'd3) && !rx_empty;
  // A full RX FIFO still takes a byte when an APB read frees a slot in the same cycle.
  assign rx_push = rx_valid && (!rx_full || rx_pop);
  assign ovf_set = rx_valid && rx_full && !rx_pop;
  assign ovf_clr = wr_commit && (reg_sel == 3'd1) && pwdata[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      start_q   <= 1'b0;
      addr_q    <= 7'd0;
      ovf_q     <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      start_q <= wr_commit && (reg_sel == 3'd0) && pwdata[1];
      if (wr_commit && (reg_sel == 3'd0)) en_q   <= pwdata[0];
      if (wr_commit && (reg_sel == 3'd4)) addr_q <= pwdata[6:0];
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= pwdata;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

  assign i2c_en    = en_q;
  assign i2c_start = start_q;
  assign i2c_addr  = addr_q;
  assign tx_data   = tx_mem[tx_rptr_q];
  assign tx_valid  = !tx_empty;

endmodule

// File: tb/tb_apb_i2c_completer.sv
// Scoreboard bench for apb_i2c_completer: APB responses and TX bytes are queued
// as expectations at issue time and checked by a monitor on the falling edge.
module tb_apb_i2c_completer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       i2c_en, i2c_start;
  logic [6:0] i2c_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       i2c_busy = 1'b0;

  int total = 0;
  int bad   = 0;
  int lat;

  logic [8:0] rsp_q [$];
  logic [7:0] txb_q [$];
  logic [8:0] e9;
  logic [7:0] e8;

  always #5 clk = ~clk;

  apb_i2c_completer #(.FIFO_DEPTH(4), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .i2c_en(i2c_en), .i2c_start(i2c_start),
    .i2c_addr(i2c_addr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .i2c_busy(i2c_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic eerr(input logic x);
`ifdef APB_SLVERR_EN
    return x;
`else
    return 1'b0;
`endif
  endfunction

  // One APB transfer; the expected {prdata, pslverr} is queued before it starts.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input logic exp_err);
    bit done;
    rsp_q.push_back({exp_rd, eerr(exp_err)});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (pready) begin done = 1'b1; lat = i; end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    if (!done) chk("apb_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && pready) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_pready", {prdata, pslverr}, 32'h1ff);
      end else begin
        e9 = rsp_q.pop_front();
        chk("apb_rsp{prdata,pslverr}", {prdata, pslverr}, e9);
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      if (txb_q.size() == 0) begin
        chk("unexpected_tx_pop", tx_data, 32'h1ff);
      end else begin
        e8 = txb_q.pop_front();
        chk("tx_data", tx_data, e8);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_prdata_pslverr", {prdata, pslverr}, 0);
    chk("rst_en_start_addr", {i2c_en, i2c_start, i2c_addr}, 0);
    chk("rst_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    apb(1'b0, 8'h01, 8'h00, 8'h0A, 1'b0);
    chk("status_latency", lat, 2);

    apb(1'b1, 8'h00, 8'h03, 8'h00, 1'b0);
    chk("start_pulse_hi", {i2c_en, i2c_start}, 2'b11);
    @(posedge clk); #1;
    chk("start_pulse_lo", {i2c_en, i2c_start}, 2'b10);
    apb(1'b0, 8'h00, 8'h00, 8'h01, 1'b0);

    apb(1'b1, 8'h04, 8'hFF, 8'h00, 1'b0);
    chk("i2c_addr", i2c_addr, 7'h7F);
    apb(1'b0, 8'h04, 8'h00, 8'h7F, 1'b0);

    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      apb(1'b1, 8'h02, 8'(i * 8'h11), 8'h00, 1'b0);
      txb_q.push_back(8'(i * 8'h11));
    end
    apb(1'b1, 8'h02, 8'h55, 8'h00, 1'b1);
    apb(1'b0, 8'h01, 8'h00, 8'h09, 1'b0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!tx_valid) break;
    end
    tx_ready = 1'b0;
    chk("tx_drained_valid", tx_valid, 0);
    chk("tx_all_popped", txb_q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'(8'hA0 + i);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    apb(1'b0, 8'h01, 8'h00, 8'h26, 1'b0);
    for (int i = 0; i < 4; i++) apb(1'b0, 8'h03, 8'h00, 8'(8'hA0 + i), 1'b0);
    apb(1'b0, 8'h03, 8'h00, 8'h00, 1'b1);
    apb(1'b1, 8'h01, 8'h20, 8'h00, 1'b0);
    i2c_busy = 1'b1;
    apb(1'b0, 8'h01, 8'h00, 8'h1A, 1'b0);
    i2c_busy = 1'b0;

    apb(1'b0, 8'h08, 8'h00, 8'h00, 1'b1);
    apb(1'b1, 8'h06, 8'h5A, 8'h00, 1'b1);
    apb(1'b0, 8'h06, 8'h00, 8'h00, 1'b1);
    apb(1'b1, 8'h03, 8'h12, 8'h00, 1'b1);
    apb(1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

    // psel dropped in the first ACCESS cycle of a TXDATA write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_push", tx_valid, 0);
    apb(1'b0, 8'h01, 8'h00, 8'h0A, 1'b0);

    // reset asserted during ACCESS of a CTRL write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h01;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pready", pready, 0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("rst_mid_en_addr", {i2c_en, i2c_addr}, 0);
    chk("rst_mid_pready_after", pready, 0);
    apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("post_rst_latency", lat, 2);

    repeat (3) @(posedge clk);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
